mcu_core_p: RTL

Parametrised accumulator MCU core: next generation of the team's 8-bit, 5-bit-address, 3-bit-opcode CISC controller.
- Data and address widths are configurable; memory-ready handshake for wait-state memories; halt/resume.
- Fetches, decodes and executes single-accumulator instructions from one shared external memory port.
- Exposes internal registers for board-level debug.

---
 rtl/mcu_core_p.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mcu_core_p.sv
// mcu_core_p: parametrised single-accumulator core sharing one memory port for code and data.
// Define MCU_CORE_WAIT_EN to honour mem_ready wait states; otherwise every access completes in one cycle.
module mcu_core_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              resume,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic [DATA_W-1:0] ir_out,
    output logic              zero_flag,
    output logic [2:0]        state_out
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        LOAD   = 3'd2,
        EXEC   = 3'd3,
        STORE  = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    if (DATA_W < ADDR_W + 3) begin : g_bad_widths
        $error("mcu_core_p: DATA_W must be at least ADDR_W+3");
    end

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   pc_r, pc_s;
    logic [DATA_W-1:0]   acc_r, acc_s;
    logic [DATA_W-1:0]   ir_r, ir_s;
    logic [DATA_W-1:0]   mdr_r, mdr_s;
    logic                zf_r, zf_s;
    logic                ready_s;
    logic [2:0]          opcode_s;
    logic [ADDR_W-1:0]   operand_s;
    logic [DATA_W-1:0]   alu_s;

`ifdef MCU_CORE_WAIT_EN
    assign ready_s = mem_ready;
`else
    assign ready_s = mem_ready | 1'b1;
`endif

    assign opcode_s  = ir_r[DATA_W-1 -: 3];
    assign operand_s = ir_r[ADDR_W-1:0];

    // LDA simply passes the memory operand through; ADD drops the carry.
    function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD:  alu = a + b;
            OP_AND:  alu = a & b;
            OP_XOR:  alu = a ^ b;
            default: alu = b;
        endcase
    endfunction

    // Next-state, register updates and memory strobes
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        acc_s    = acc_r;
        ir_s     = ir_r;
        mdr_s    = mdr_r;
        zf_s     = zf_r;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = pc_r;
        halted   = 1'b0;
        alu_s    = alu(opcode_s, acc_r, mdr_r);
        case (state_r)
            FETCH: begin
                mem_rd = 1'b1;
                if (ready_s) begin
                    ir_s    = mem_rdata;
                    pc_s    = pc_r + PC_ONE;
                    state_s = DECODE;
                end else begin
                    state_s = FETCH;
                end
            end
            DECODE: begin
                case (opcode_s)
                    OP_HLT: state_s = HALT;
                    OP_SKZ: begin
                        if (zf_r) begin
                            pc_s = pc_r + PC_ONE;
                        end else begin
                            pc_s = pc_r;
                        end
                        state_s = FETCH;
                    end
                    OP_JMP: begin
                        pc_s    = operand_s;
                        state_s = FETCH;
                    end
                    OP_STO:  state_s = STORE;
                    default: state_s = LOAD;
                endcase
            end
            LOAD: begin
                mem_rd   = 1'b1;
                mem_addr = operand_s;
                if (ready_s) begin
                    mdr_s   = mem_rdata;
                    state_s = EXEC;
                end else begin
                    state_s = LOAD;
                end
            end
            EXEC: begin
                acc_s   = alu_s;
                zf_s    = (alu_s == {DATA_W{1'b0}});
                state_s = FETCH;
            end
            STORE: begin
                mem_wr   = 1'b1;
                mem_addr = operand_s;
                if (ready_s) begin
                    state_s = FETCH;
                end else begin
                    state_s = STORE;
                end
            end
            HALT: begin
                halted = 1'b1;
                if (resume) begin
                    state_s = FETCH;
                end else begin
                    state_s = HALT;
                end
            end
            default: state_s = FETCH;
        endcase
    end

    // Architectural state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
            pc_r    <= {ADDR_W{1'b0}};
            acc_r   <= {DATA_W{1'b0}};
            ir_r    <= {DATA_W{1'b0}};
            mdr_r   <= {DATA_W{1'b0}};
            zf_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            acc_r   <= acc_s;
            ir_r    <= ir_s;
            mdr_r   <= mdr_s;
            zf_r    <= zf_s;
        end
    end

    assign mem_wdata = acc_r;
    assign pc_out    = pc_r;
    assign acc_out   = acc_r;
    assign ir_out    = ir_r;
    assign zero_flag = zf_r;
    assign state_out = state_r;
endmodule
